// File: rtl/cpu_pkg.sv
// Shared encodings, ALU/forwarding enums and pipeline-register layouts for the
// five-stage cpu. Optional multiplier is controlled by CPU_MUL_EN.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_MUL = 6'h18;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_MUL
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_NONE,
    FWD_EXMEM,
    FWD_MEMWB
  } fwd_sel_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } if_id_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        use_imm;
    alu_op_e     alu_op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
  } id_ex_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        mem_to_reg;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] store_data;
  } ex_mem_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] mem_data;
  } mem_wb_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/cpu_if.sv
// Data-memory bus between the MEM stage (master) and the byte-array data memory (slave).
interface cpu_if;
  logic        we;
  logic [2:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output we, waddr, wdata, input rdata);
  modport slave  (input we, waddr, wdata, output rdata);
endinterface

// File: rtl/cpu_hazard.sv
// hazard_unit: load-use interlock detection and EX operand forwarding selects.
module hazard_unit
  import cpu_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic [4:0] ex_rd,
  input  logic       mem_reg_write,
  input  logic [4:0] mem_rd,
  input  logic       wb_reg_write,
  input  logic [4:0] wb_rd,
  output logic       lw_stall,
  output fwd_sel_e   fwd_a,
  output fwd_sel_e   fwd_b
);

  function automatic fwd_sel_e pick(input logic [4:0] src,
                                    input logic mem_we, input logic [4:0] mem_dst,
                                    input logic wb_we, input logic [4:0] wb_dst);
    if (src == '0)
      return FWD_NONE;
    else if (mem_we && mem_dst == src)
      return FWD_EXMEM;
    else if (wb_we && wb_dst == src)
      return FWD_MEMWB;
    else
      return FWD_NONE;
  endfunction

  always_comb begin
    lw_stall = ex_mem_read && (ex_rd == id_rs || ex_rd == id_rt);
    fwd_a    = pick(ex_rs, mem_reg_write, mem_rd, wb_reg_write, wb_rd);
    fwd_b    = pick(ex_rt, mem_reg_write, mem_rd, wb_reg_write, wb_rd);
  end

endmodule

// File: rtl/cpu_state.sv
// Architectural state holders of the cpu: PC register, register file,
// instruction memory and byte-addressed data memory.
module cpu_pc (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en,
  input  logic [31:0] pc_next,
  output logic [31:0] pc_o
);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      pc_o <= '0;
    else if (en)
      pc_o <= pc_next;
  end
endmodule

module cpu_regfile (
  input  logic        clk_i,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] register [0:31];

  always_ff @(posedge clk_i) begin
    if (we && wa != '0)
      register[wa] <= wd;
  end

  // Write-through so ID sees the value WB commits on the coming edge.
  assign rd1 = (ra1 == '0) ? '0 : (we && wa == ra1) ? wd : register[ra1];
  assign rd2 = (ra2 == '0) ? '0 : (we && wa == ra2) ? wd : register[ra2];
endmodule

module cpu_imem (
  input  logic        clk_i,
  input  logic        we,
  input  logic [7:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [7:0]  addr,
  output logic [31:0] data
);
  logic [31:0] memory [0:255];

  // Loader port; the core itself never writes program memory.
  always_ff @(posedge clk_i) begin
    if (we)
      memory[waddr] <= wdata;
  end

  assign data = memory[addr];
endmodule

module cpu_dmem (
  input logic   clk_i,
  cpu_if.slave  bus
);
  logic [7:0] memory [0:31];

  always_ff @(posedge clk_i) begin
    if (bus.we) begin
      memory[{bus.waddr, 2'd0}] <= bus.wdata[7:0];
      memory[{bus.waddr, 2'd1}] <= bus.wdata[15:8];
      memory[{bus.waddr, 2'd2}] <= bus.wdata[23:16];
      memory[{bus.waddr, 2'd3}] <= bus.wdata[31:24];
    end
  end

  assign bus.rdata = {memory[{bus.waddr, 2'd3}], memory[{bus.waddr, 2'd2}],
                      memory[{bus.waddr, 2'd1}], memory[{bus.waddr, 2'd0}]};
endmodule

// File: rtl/cpu.sv
// Five-stage MIPS-subset pipeline (IF/ID/EX/MEM/WB) with branch resolution in ID.
// Define CPU_MUL_EN to decode and execute mul; otherwise mul is a NOP.
module cpu
  import cpu_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i
);

  logic        lw_stall;
  logic        beq_flush;

  logic [31:0] pc, pc4, pc_next, instr;
  logic        pc_en;

  if_id_t      if_id;
  id_ex_t      id_ex, id_ctrl;
  ex_mem_t     ex_mem;
  mem_wb_t     mem_wb;

  logic [5:0]  id_op, id_funct;
  logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
  logic [15:0] id_imm;
  logic [25:0] id_jidx;
  logic [31:0] id_rs_val, id_rt_val, id_imm_sext, br_target, j_target;
  logic        beq_taken, j_taken;

  fwd_sel_e    fwd_a, fwd_b;
  logic [31:0] ex_a, ex_b_reg, ex_b, ex_result;

  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  cpu_if dbus ();

  // ---------------- IF ----------------
  cpu_pc PC (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en      (pc_en),
    .pc_next (pc_next),
    .pc_o    (pc)
  );

  cpu_imem Instruction_Memory (
    .clk_i (clk_i),
    .we    (1'b0),
    .waddr ('0),
    .wdata ('0),
    .addr  (pc[9:2]),
    .data  (instr)
  );

  assign pc4 = pc + 32'd4;

  // A stall freezes fetch even if ID holds a taken branch; it resolves next cycle.
  always_comb begin
    pc_en   = 1'b0;
    pc_next = pc4;
    if (!lw_stall) begin
      if (beq_taken || j_taken) begin
        pc_en   = 1'b1;
        pc_next = beq_taken ? br_target : j_target;
      end else if (start_i) begin
        pc_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      if_id <= '0;
    end else if (!lw_stall) begin
      if (beq_taken || j_taken || !start_i) begin
        if_id <= '0;
      end else begin
        if_id.instr <= instr;
        if_id.pc4   <= pc4;
      end
    end
  end

  // ---------------- ID ----------------
  assign id_op       = if_id.instr[31:26];
  assign id_rs       = if_id.instr[25:21];
  assign id_rt       = if_id.instr[20:16];
  assign id_rd       = if_id.instr[15:11];
  assign id_shamt    = if_id.instr[10:6];
  assign id_funct    = if_id.instr[5:0];
  assign id_imm      = if_id.instr[15:0];
  assign id_jidx     = if_id.instr[25:0];
  assign id_imm_sext = sext16(id_imm);

  cpu_regfile Registers (
    .clk_i (clk_i),
    .we    (wb_we),
    .wa    (wb_rd),
    .wd    (wb_data),
    .ra1   (id_rs),
    .ra2   (id_rt),
    .rd1   (id_rs_val),
    .rd2   (id_rt_val)
  );

  assign br_target = if_id.pc4 + (id_imm_sext << 2);
  assign j_target  = {if_id.pc4[31:28], id_jidx, 2'b00};
  assign beq_taken = (id_op == OP_BEQ) && (id_rs_val == id_rt_val);
  assign j_taken   = (id_op == OP_J);
  assign beq_flush = beq_taken && !lw_stall;

  always_comb begin
    id_ctrl        = '0;
    id_ctrl.alu_op = ALU_ADD;
    id_ctrl.rs     = id_rs;
    id_ctrl.rt     = id_rt;
    id_ctrl.rs_val = id_rs_val;
    id_ctrl.rt_val = id_rt_val;
    id_ctrl.imm    = id_imm_sext;
    case (id_op)
      OP_RTYPE: begin
        if (id_shamt == '0) begin
          id_ctrl.rd = id_rd;
          case (id_funct)
            FN_ADD: begin id_ctrl.reg_write = 1'b1; id_ctrl.alu_op = ALU_ADD; end
            FN_SUB: begin id_ctrl.reg_write = 1'b1; id_ctrl.alu_op = ALU_SUB; end
            FN_AND: begin id_ctrl.reg_write = 1'b1; id_ctrl.alu_op = ALU_AND; end
            FN_OR:  begin id_ctrl.reg_write = 1'b1; id_ctrl.alu_op = ALU_OR;  end
`ifdef CPU_MUL_EN
            FN_MUL: begin id_ctrl.reg_write = 1'b1; id_ctrl.alu_op = ALU_MUL; end
`endif
            default: ;
          endcase
        end
      end
      OP_ADDI: begin
        id_ctrl.reg_write = 1'b1;
        id_ctrl.use_imm   = 1'b1;
        id_ctrl.rd        = id_rt;
      end
      OP_LW: begin
        id_ctrl.reg_write  = 1'b1;
        id_ctrl.mem_read   = 1'b1;
        id_ctrl.mem_to_reg = 1'b1;
        id_ctrl.use_imm    = 1'b1;
        id_ctrl.rd         = id_rt;
      end
      OP_SW: begin
        id_ctrl.mem_write = 1'b1;
        id_ctrl.use_imm   = 1'b1;
      end
      default: ;
    endcase
  end

  hazard_unit hazard (
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .ex_mem_read   (id_ex.mem_read),
    .ex_rs         (id_ex.rs),
    .ex_rt         (id_ex.rt),
    .ex_rd         (id_ex.rd),
    .mem_reg_write (ex_mem.reg_write),
    .mem_rd        (ex_mem.rd),
    .wb_reg_write  (mem_wb.reg_write),
    .wb_rd         (mem_wb.rd),
    .lw_stall      (lw_stall),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      id_ex <= '0;
    else if (lw_stall)
      id_ex <= '0;
    else
      id_ex <= id_ctrl;
  end

  // ---------------- EX ----------------
  always_comb begin
    ex_a = id_ex.rs_val;
    case (fwd_a)
      FWD_EXMEM: ex_a = ex_mem.alu;
      FWD_MEMWB: ex_a = wb_data;
      default:   ;
    endcase
    ex_b_reg = id_ex.rt_val;
    case (fwd_b)
      FWD_EXMEM: ex_b_reg = ex_mem.alu;
      FWD_MEMWB: ex_b_reg = wb_data;
      default:   ;
    endcase
  end

  assign ex_b = id_ex.use_imm ? id_ex.imm : ex_b_reg;

  always_comb begin
    ex_result = '0;
    case (id_ex.alu_op)
      ALU_ADD: ex_result = ex_a + ex_b;
      ALU_SUB: ex_result = ex_a - ex_b;
      ALU_AND: ex_result = ex_a & ex_b;
      ALU_OR:  ex_result = ex_a | ex_b;
`ifdef CPU_MUL_EN
      ALU_MUL: ex_result = ex_a * ex_b;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_mem <= '0;
    end else begin
      ex_mem.reg_write  <= id_ex.reg_write;
      ex_mem.mem_write  <= id_ex.mem_write;
      ex_mem.mem_to_reg <= id_ex.mem_to_reg;
      ex_mem.rd         <= id_ex.rd;
      ex_mem.alu        <= ex_result;
      ex_mem.store_data <= ex_b_reg;
    end
  end

  // ---------------- MEM ----------------
  assign dbus.we    = ex_mem.mem_write;
  assign dbus.waddr = ex_mem.alu[4:2];
  assign dbus.wdata = ex_mem.store_data;

  cpu_dmem Data_Memory (
    .clk_i (clk_i),
    .bus   (dbus)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_wb <= '0;
    end else begin
      mem_wb.reg_write  <= ex_mem.reg_write;
      mem_wb.mem_to_reg <= ex_mem.mem_to_reg;
      mem_wb.rd         <= ex_mem.rd;
      mem_wb.alu        <= ex_mem.alu;
      mem_wb.mem_data   <= dbus.rdata;
    end
  end

  // ---------------- WB ----------------
  assign wb_we   = mem_wb.reg_write;
  assign wb_rd   = mem_wb.rd;
  assign wb_data = mem_wb.mem_to_reg ? mem_wb.mem_data : mem_wb.alu;

endmodule

// File: tb/tb_cpu.sv
// Directed-program bench for cpu: expected register commits are queued per
// program and a negedge monitor pops and compares them as WB presents writes.
module tb_cpu;

  logic clk_i   = 1'b0;
  logic rst_i   = 1'b1;
  logic start_i = 1'b0;

  cpu dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
  } commit_t;

  commit_t exp_q[$];
  int n_checks  = 0;
  int n_pass    = 0;
  int stall_cnt = 0;
  int flush_cnt = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] jtype(input logic [25:0] idx);
    return {6'h02, idx};
  endfunction

  function automatic void expect_commit(input logic [4:0] rd, input logic [31:0] val);
    commit_t c;
    c.rd  = rd;
    c.val = val;
    exp_q.push_back(c);
  endfunction

  // Monitor: hazard event counts and commit scoreboard.
  always @(negedge clk_i) begin : monitor
    commit_t e;
    if (!rst_i) begin
      if (dut.lw_stall)  stall_cnt++;
      if (dut.beq_flush) flush_cnt++;
      if (dut.wb_we && dut.wb_rd != 5'd0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL commit: unexpected write r%0d=%h, expected no commit", dut.wb_rd, dut.wb_data);
        end else begin
          e = exp_q.pop_front();
          check("commit_rd", {27'd0, dut.wb_rd}, {27'd0, e.rd});
          check("commit_val", dut.wb_data, e.val);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic begin_test();
    rst_i   = 1'b1;
    start_i = 1'b0;
    for (int i = 0; i < 256; i++) dut.Instruction_Memory.memory[i] = 32'h0;
    for (int i = 0; i < 32; i++)  dut.Data_Memory.memory[i] = 8'h00;
    for (int i = 1; i < 32; i++)  dut.Registers.register[i] = 32'h0;
    exp_q.delete();
  endtask

  task automatic run(input int n);
    tick(1);
    stall_cnt = 0;
    flush_cnt = 0;
    rst_i     = 1'b0;
    start_i   = 1'b1;
    tick(n);
    start_i   = 1'b0;
    tick(6);
  endtask

  task automatic end_test(input string name);
    check({name, "_drained"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset and start gating
    begin_test();
    tick(2);
    rst_i = 1'b0;
    check("reset_pc", dut.PC.pc_o, 32'd0);
    check("reset_lw_stall", {31'd0, dut.lw_stall}, 32'd0);
    check("reset_beq_flush", {31'd0, dut.beq_flush}, 32'd0);
    tick(1);
    check("idle_pc_1", dut.PC.pc_o, 32'd0);
    tick(1);
    check("idle_pc_2", dut.PC.pc_o, 32'd0);
    start_i = 1'b1;
    tick(1);
    check("run_pc_4", dut.PC.pc_o, 32'd4);
    tick(1);
    check("run_pc_8", dut.PC.pc_o, 32'd8);
    tick(1);
    check("run_pc_12", dut.PC.pc_o, 32'd12);
    start_i = 1'b0;
    tick(6);

    // ALU chain exercising EX/MEM and MEM/WB forwarding
    begin_test();
    dut.Instruction_Memory.memory[0] = itype(6'h08, 5'd0, 5'd8, 16'd5);
    dut.Instruction_Memory.memory[1] = itype(6'h08, 5'd8, 5'd9, 16'd3);
    dut.Instruction_Memory.memory[2] = rtype(5'd10, 5'd9, 5'd8, 6'h22);
    dut.Instruction_Memory.memory[3] = rtype(5'd11, 5'd10, 5'd9, 6'h25);
    expect_commit(5'd8, 32'd5);
    expect_commit(5'd9, 32'd8);
    expect_commit(5'd10, 32'd3);
    expect_commit(5'd11, 32'd11);
    run(12);
    check("alu_r8", dut.Registers.register[8], 32'd5);
    check("alu_r11", dut.Registers.register[11], 32'd11);
    check("alu_stalls", stall_cnt, 32'd0);
    end_test("alu");

    // Load-use interlock
    begin_test();
    dut.Data_Memory.memory[0] = 8'h05;
    dut.Instruction_Memory.memory[0] = itype(6'h23, 5'd0, 5'd8, 16'd0);
    dut.Instruction_Memory.memory[1] = rtype(5'd9, 5'd8, 5'd8, 6'h20);
    expect_commit(5'd8, 32'd5);
    expect_commit(5'd9, 32'd10);
    run(10);
    check("lu_stalls", stall_cnt, 32'd1);
    check("lu_r9", dut.Registers.register[9], 32'd10);
    end_test("loaduse");

    // Store/load round trip, little-endian bytes
    begin_test();
    dut.Instruction_Memory.memory[0] = itype(6'h08, 5'd0, 5'd8, 16'hFFFE);
    dut.Instruction_Memory.memory[1] = itype(6'h2B, 5'd0, 5'd8, 16'd4);
    dut.Instruction_Memory.memory[2] = itype(6'h23, 5'd0, 5'd9, 16'd4);
    expect_commit(5'd8, 32'hFFFF_FFFE);
    expect_commit(5'd9, 32'hFFFF_FFFE);
    run(10);
    check("st_byte4", {24'd0, dut.Data_Memory.memory[4]}, 32'hFE);
    check("st_byte5", {24'd0, dut.Data_Memory.memory[5]}, 32'hFF);
    check("st_byte6", {24'd0, dut.Data_Memory.memory[6]}, 32'hFF);
    check("st_byte7", {24'd0, dut.Data_Memory.memory[7]}, 32'hFF);
    check("st_byte3", {24'd0, dut.Data_Memory.memory[3]}, 32'h00);
    check("st_r9", dut.Registers.register[9], 32'hFFFF_FFFE);
    check("st_stalls", stall_cnt, 32'd0);
    end_test("storeload");

    // beq not taken then taken on the second pass after j back to start
    begin_test();
    dut.Registers.register[8] = 32'd1;
    dut.Instruction_Memory.memory[0] = itype(6'h04, 5'd8, 5'd9, 16'd4);
    dut.Instruction_Memory.memory[1] = itype(6'h08, 5'd0, 5'd9, 16'd1);
    dut.Instruction_Memory.memory[4] = jtype(26'd0);
    dut.Instruction_Memory.memory[5] = itype(6'h08, 5'd0, 5'd10, 16'd7);
    dut.Instruction_Memory.memory[6] = jtype(26'd8);
    dut.Instruction_Memory.memory[7] = itype(6'h08, 5'd0, 5'd11, 16'd55);
    dut.Instruction_Memory.memory[8] = itype(6'h08, 5'd0, 5'd12, 16'd3);
    expect_commit(5'd9, 32'd1);
    expect_commit(5'd10, 32'd7);
    expect_commit(5'd12, 32'd3);
    run(30);
    check("br_flushes", flush_cnt, 32'd1);
    check("br_r11_untouched", dut.Registers.register[11], 32'd0);
    check("br_r12", dut.Registers.register[12], 32'd3);
    check("br_stalls", stall_cnt, 32'd0);
    end_test("branch");

    // Multiply
    begin_test();
    dut.Registers.register[8]  = 32'd7;
    dut.Registers.register[9]  = 32'd6;
    dut.Registers.register[10] = 32'h123;
    dut.Instruction_Memory.memory[0] = rtype(5'd10, 5'd8, 5'd9, 6'h18);
`ifdef CPU_MUL_EN
    expect_commit(5'd10, 32'd42);
    run(10);
    check("mul_r10", dut.Registers.register[10], 32'd42);
`else
    run(10);
    check("mul_r10", dut.Registers.register[10], 32'h123);
`endif
    end_test("mul");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
